// File: rtl/diff_mon_pkg.sv
// rtl/diff_mon_pkg.sv - shared types and defaults for the differential blink monitor
//
// Holds the FSM state encoding and the default parameter values used by
// diff_blink_monitor and its interface.
package diff_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W       = 26;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 50_000_000;
  localparam int DEF_TOL         = 4;
  localparam int DEF_LOCK_COUNT  = 4;

endpackage

// File: rtl/diff_blink_monitor_if.sv
// rtl/diff_blink_monitor_if.sv - pad pair and status bundle of the blink monitor
//
// master : drives the differential pads, observes status (board side / bench)
// slave  : the monitor; samples the pads, drives level/period/status
//   sig_p, sig_n  differential input pads
//   level         synchronised level
//   period        last measured rise-to-rise period in clk cycles
//   period_valid  one-cycle pulse when period updates
//   locked        period stable within tolerance
//   timeout       no rising edge within the timeout window
interface diff_blink_monitor_if
  import diff_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             sig_p;
  logic             sig_n;
  logic             level;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  modport master (
    output sig_p, sig_n,
    input  level, period, period_valid, locked, timeout
  );

  modport slave (
    input  sig_p, sig_n,
    output level, period, period_valid, locked, timeout
  );
endinterface

// File: rtl/IBUFDS.sv
// rtl/IBUFDS.sv - behavioural stand-in for the differential input buffer primitive
//
// Ports: I (positive pad), IB (negative pad), O (single-ended level).
// A non-differential pair (both pads equal) reads as 0.
module IBUFDS (
  input  logic I,
  input  logic IB,
  output logic O
);
  assign O = (I != IB) ? I : 1'b0;
endmodule

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - plain flop-chain synchroniser for pad-to-clk crossings
//
// Ports: clk, rst_n (sync, active-low), d (async input), q (synchronised output).
// STAGES must be at least 2.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/diff_blink_monitor.sv
// rtl/diff_blink_monitor.sv - period / lock / loss checker for a differential toggle line
//
// Ports:
//   clk    system clock (post clock buffer)
//   rst_n  synchronous active-low reset
//   bus    diff_blink_monitor_if.slave: sig_p/sig_n in; level, period,
//          period_valid, locked, timeout out (all registered)
module diff_blink_monitor
  import diff_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
  input logic                clk,
  input logic                rst_n,
  diff_blink_monitor_if.slave bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_C  = MW'(LOCK_COUNT);

  // Pad input and synchronisation
  logic pad_level;
  logic level_s;
  logic level_d;
  logic rise;

  IBUFDS u_ibufds (
    .I  (bus.sig_p),
    .IB (bus.sig_n),
    .O  (pad_level)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_level),
    .q     (level_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level_s;
    end
  end

  assign rise      = level_s & ~level_d;
  assign bus.level = level_s;

  // Free-running interval counter, restarted by every rise, saturating
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Period of the interval closed by this cycle's rise
  logic [CNT_W-1:0] meas;
  logic [CNT_W-1:0] prev;
  logic             prev_valid;
  logic [CNT_W-1:0] diff;
  logic             in_tol;
  logic             expire;

  assign meas   = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign diff   = (meas > prev) ? (meas - prev) : (prev - meas);
  assign in_tol = prev_valid && (diff <= TOL_C);
  assign expire = (cnt == TO_LAST) && !rise;

  // FSM and registered outputs
  mon_state_t       state, state_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [CNT_W-1:0] prev_nxt;
  logic             prev_valid_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic             pv_q, pv_nxt;
  logic             locked_q, locked_nxt;
  logic             timeout_q, timeout_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      match_cnt  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= match_nxt;
      prev       <= prev_nxt;
      prev_valid <= prev_valid_nxt;
      period_q   <= period_nxt;
      pv_q       <= pv_nxt;
      locked_q   <= locked_nxt;
      timeout_q  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    match_nxt      = match_cnt;
    prev_nxt       = prev;
    prev_valid_nxt = prev_valid;
    period_nxt     = period_q;
    pv_nxt         = 1'b0;
    locked_nxt     = locked_q;
    timeout_nxt    = timeout_q;

    case (state)
      IDLE: begin
        // First rise only opens a measurement; the interval before it is partial.
        if (rise) begin
          state_nxt      = MEASURE;
          timeout_nxt    = 1'b0;
          match_nxt      = '0;
          prev_valid_nxt = 1'b0;
        end
      end

      MEASURE, LOCKED: begin
        if (rise) begin
          period_nxt     = meas;
          pv_nxt         = 1'b1;
          prev_nxt       = meas;
          prev_valid_nxt = 1'b1;
          if (state == MEASURE) begin
            if (in_tol) begin
              match_nxt = match_cnt + 1'b1;
              if (match_nxt == LOCK_C) begin
                state_nxt  = LOCKED;
                locked_nxt = 1'b1;
              end
            end else begin
              match_nxt = '0;
            end
          end else if (!in_tol) begin
            state_nxt  = MEASURE;
            locked_nxt = 1'b0;
            match_nxt  = '0;
          end
        end else if (expire) begin
          // Loss of activity: drop back and forget the reference period;
          // the last period value is kept for inspection.
          state_nxt      = IDLE;
          timeout_nxt    = 1'b1;
          locked_nxt     = 1'b0;
          match_nxt      = '0;
          prev_valid_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_diff_blink_monitor.sv
// tb/tb_diff_blink_monitor.sv - self-checking bench for diff_blink_monitor
module tb_diff_blink_monitor;
  localparam int CNT_W = 26;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  diff_blink_monitor_if #(.CNT_W(CNT_W)) bus ();

  diff_blink_monitor #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .TIMEOUT     (100),
    .TOL         (4),
    .LOCK_COUNT  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               hi;
    int               lo;
    logic [CNT_W-1:0] exp_period;
    logic             exp_locked;
  } vec_t;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic             locked;
    int               at;
  } rec_t;

  vec_t vecs[21];
  rec_t q[$];

  always @(negedge clk) begin
    if (bus.period_valid) q.push_back('{bus.period, bus.locked, cyc});
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.sig_p = v;
    bus.sig_n = ~v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive rows [first, first+n) as high/low phases, close with a final rise,
  // then compare every period_valid pulse against the table.
  task automatic run_rows(input int first, input int n);
    q.delete();
    for (int i = first; i < first + n; i++) begin
      hold(1'b1, vecs[i].hi);
      hold(1'b0, vecs[i].lo);
    end
    hold(1'b1, 6);
    check("pulse_count", q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      check($sformatf("period[%0d]", first + i), q[i].period, vecs[first + i].exp_period);
      check($sformatf("locked[%0d]", first + i), q[i].locked, vecs[first + i].exp_locked);
    end
  endtask

  initial begin
    int last_at;
    int seen;
    checks = 0;
    errors = 0;

    // 16-cycle square wave: lock on the 5th valid period
    for (int i = 0; i < 6; i++) vecs[i] = '{8, 8, 16, (i >= 4)};
    // Jitter 15/17 around 16 while locked
    vecs[6]  = '{7, 8, 15, 1'b1};
    vecs[7]  = '{9, 8, 17, 1'b1};
    vecs[8]  = '{7, 8, 15, 1'b1};
    vecs[9]  = '{9, 8, 17, 1'b1};
    // Step to 24 drops lock, four more 24s relock
    vecs[10] = '{12, 12, 24, 1'b0};
    for (int i = 11; i < 15; i++) vecs[i] = '{12, 12, 24, (i == 14)};
    // Toggle every cycle: period 2, relock after step
    for (int i = 15; i < 21; i++) vecs[i] = '{1, 1, 2, (i >= 19)};

    // Reset held with toggling input
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) hold(i[0], 1);
    check("rst_level", bus.level, 0);
    check("rst_period", bus.period, 0);
    check("rst_period_valid", bus.period_valid, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_pulses", q.size(), 0);
    hold(1'b0, 1);
    rst_n = 1'b1;
    hold(1'b0, 5);

    run_rows(0, 21);

    // Loss of activity: input stuck high after the final rise
    last_at = (q.size() > 0) ? q[q.size()-1].at : cyc;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.timeout) seen = 1;
    end
    check("timeout_seen", seen, 1);
    check("timeout_delay", cyc - last_at, 100);
    check("timeout_locked", bus.locked, 0);
    check("timeout_period_hold", bus.period, 2);
    @(posedge clk);
    #1;

    // Resume: first rise clears timeout without a period, second gives one
    q.delete();
    hold(1'b0, 4);
    hold(1'b1, 8);
    hold(1'b0, 8);
    check("resume_timeout_clr", bus.timeout, 0);
    check("resume_no_pulse", q.size(), 0);
    hold(1'b1, 8);
    hold(1'b0, 8);
    check("resume_pulses", q.size(), 1);
    if (q.size() > 0) begin
      check("resume_period", q[0].period, 16);
      check("resume_locked", q[0].locked, 0);
    end
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    hold(1'b1, 6);
    check("relock_pulses", q.size(), 5);
    if (q.size() == 5) begin
      check("relock_pre", q[3].locked, 0);
      check("relock_locked", q[4].locked, 1);
    end
    check("relock_out", bus.locked, 1);

    // One-cycle reset while locked
    hold(1'b0, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_level", bus.level, 0);
    check("mid_rst_period", bus.period, 0);
    check("mid_rst_pv", bus.period_valid, 0);
    check("mid_rst_locked", bus.locked, 0);
    check("mid_rst_timeout", bus.timeout, 0);
    check("mid_rst_state", dut.state, 0);
    hold(1'b0, 4);
    run_rows(0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
